// File: rtl/fetch_unit_if.sv
// System bus seen by the fetch unit: a request channel (address + tag) and a
// response channel returning one data beat per cycle of a line fill.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

interface fetch_unit_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic                      bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_respcyc;
  logic                      bus_respack;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

  // Requester side (the fetch unit).
  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  // Memory / interconnect side.
  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests whole cache lines over the system bus,
// splits each returned beat into instructions, drops those before the fetch
// PC and queues the rest in a FIFO presented as a valid/ready stream.
// A redirect flushes the queue and drains any burst still in flight.

module fetch_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int INSTR_WIDTH    = 32,
  parameter int BURST_BEATS    = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            entry,
  input  logic                   enable,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [63:0]            instr_pc,
  output logic                   busy,
  fetch_unit_if.master           sysbus
);

  localparam int IPB         = BUS_DATA_WIDTH / INSTR_WIDTH;
  localparam int LB          = BURST_BEATS * BUS_DATA_WIDTH / 8;
  localparam int LINE_INSTRS = BURST_BEATS * IPB;
  localparam int INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W       = PTR_W + 1;
  localparam int PUSH_W      = $clog2(IPB + 1);

  localparam logic [63:0] LINE_MASK = ~(64'(LB) - 64'd1);
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG =
    {`SYSBUS_READ, `SYSBUS_MEMORY, {(BUS_TAG_WIDTH-5){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_next;

  logic [63:0]       fetch_pc;
  logic [63:0]       req_line;       // line base of the burst in flight
  logic [BEAT_W-1:0] beat_cnt;
  logic              drain_pending;  // redirect seen while waiting for reqack

  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [63:0]            pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count, fifo_free;

  logic              last_beat, beat_fire, start_fetch, pop;
  logic [63:0]       slot_pc  [IPB];
  logic [PUSH_W-1:0] slot_off [IPB];
  logic [IPB-1:0]    keep;
  logic [PUSH_W-1:0] push_cnt;

  // Response tags carry no routing information for a single-requester fetch.
  logic unused_resptag;
  assign unused_resptag = ^sysbus.bus_resptag;

  assign fifo_free   = CNT_W'(FIFO_DEPTH) - count;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign busy        = (state != IDLE);
  assign last_beat   = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
  assign beat_fire   = sysbus.bus_respcyc && (state == RESP || state == DRAIN);
  assign start_fetch = enable && !redirect_valid &&
                       (fifo_free >= CNT_W'(LINE_INSTRS));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which processes evaluate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and bus handshake outputs.
  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next         = state;
    sysbus.bus_reqcyc  = 1'b0;
    sysbus.bus_req     = '0;
    sysbus.bus_reqtag  = '0;
    sysbus.bus_respack = 1'b0;
    case (state)
      IDLE: begin
        if (start_fetch) state_next = REQ;
      end
      REQ: begin
        sysbus.bus_reqcyc = 1'b1;
        sysbus.bus_req    = BUS_DATA_WIDTH'(req_line);
        sysbus.bus_reqtag = READ_TAG;
        if (sysbus.bus_reqack)
          state_next = (drain_pending || redirect_valid) ? DRAIN : RESP;
      end
      RESP: begin
        sysbus.bus_respack = sysbus.bus_respcyc;
        if (sysbus.bus_respcyc && last_beat) state_next = IDLE;
        else if (redirect_valid)             state_next = DRAIN;
      end
      DRAIN: begin
        sysbus.bus_respack = sysbus.bus_respcyc;
        if (sysbus.bus_respcyc && last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch PC, line latch, beat counter and pending-drain flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc      <= entry;
      req_line      <= '0;
      beat_cnt      <= '0;
      drain_pending <= 1'b0;
    end else begin
      if (state == IDLE && start_fetch) req_line <= fetch_pc & LINE_MASK;

      if (state == REQ) begin
        if (sysbus.bus_reqack) begin
          beat_cnt      <= '0;
          drain_pending <= 1'b0;
        end else if (redirect_valid) begin
          drain_pending <= 1'b1;
        end
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end

      // A redirect always wins over the sequential advance to the next line.
      if (redirect_valid)
        fetch_pc <= redirect_pc;
      else if (state == RESP && beat_fire && last_beat)
        fetch_pc <= req_line + 64'(LB);
    end
  end

  // Split the current beat into instruction slots and pick the ones to keep;
  // kept slots are always a contiguous upper run, packed in pc order.
  always_comb begin
    push_cnt = '0;
    keep     = '0;
    for (int i = 0; i < IPB; i++) begin
      slot_pc[i]  = req_line + 64'((int'(beat_cnt) * IPB + i) * INSTR_BYTES);
      keep[i]     = (state == RESP) && sysbus.bus_respcyc && !redirect_valid &&
                    (slot_pc[i] >= fetch_pc);
      slot_off[i] = push_cnt;
      if (keep[i]) push_cnt = push_cnt + PUSH_W'(1);
    end
  end

  // FIFO storage writes.
  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count alone, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IPB; i++) begin
      if (keep[i]) begin
        instr_mem[wr_ptr + PTR_W'(slot_off[i])] <= sysbus.bus_resp[i*INSTR_WIDTH +: INSTR_WIDTH];
        pc_mem[wr_ptr + PTR_W'(slot_off[i])]    <= slot_pc[i];
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scripted bus responder drives line
// fills, queues the instructions it expects, and a negedge monitor pops and
// compares everything the unit delivers.

`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [63:0] EXP_TAG = 64'h1100;  // {read, memory, 8'b0}

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        enable;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        busy;

  fetch_unit_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) sysbus ();

  fetch_unit #(
    .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .INSTR_WIDTH(32),
    .BURST_BEATS(8), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .entry(entry), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .busy(busy), .sysbus(sysbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [63:0] entry;
    int          ack_delay;
    logic [63:0] exp_req;
    int          exp_cnt;
    logic [63:0] exp_next;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        vecs[4];
  int          checks = 0;
  int          errors = 0;
  int          pop_count = 0;
  logic [63:0] model_pc;
  logic [63:0] cur_line;
  bit          seen;
  bit          saw_req;

  function automatic logic [31:0] mem_instr(input logic [63:0] pc);
    return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [63:0] e);
    reset = 1'b0;
    entry = e;
    redirect_valid = 1'b0;
    sysbus.bus_reqack = 1'b0;
    sysbus.bus_respcyc = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    model_pc = e;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sysbus.bus_reqcyc) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("req_seen", 64'(ok), 64'd1);
  endtask

  // Accept one request after 'delay' extra cycles; optionally redirect in its first cycle.
  task automatic do_request(input logic [63:0] exp_req, input int delay,
                            input bit redir, input logic [63:0] redir_pc);
    bit ok;
    wait_req(ok);
    check("req_addr", sysbus.bus_req, exp_req);
    check("req_tag", 64'(sysbus.bus_reqtag), EXP_TAG);
    cur_line = exp_req;
    for (int k = 0; k < delay; k++) begin
      if (redir && k == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = redir_pc;
        model_pc = redir_pc;
        exp_q.delete();
      end
      tick();
      redirect_valid = 1'b0;
      check("req_hold_cyc", 64'(sysbus.bus_reqcyc), 64'd1);
      check("req_hold_addr", sysbus.bus_req, exp_req);
      check("req_hold_tag", 64'(sysbus.bus_reqtag), EXP_TAG);
    end
    sysbus.bus_reqack = 1'b1;
    tick();
    sysbus.bus_reqack = 1'b0;
    check("reqcyc_drop", 64'(sysbus.bus_reqcyc), 64'd0);
  endtask

  task automatic send_beats(input int first, input int last, input bit push);
    logic [63:0] a;
    for (int b = first; b <= last; b++) begin
      a = cur_line + 64'(b * 8);
      sysbus.bus_respcyc = 1'b1;
      sysbus.bus_resp    = {mem_instr(a + 64'd4), mem_instr(a)};
      sysbus.bus_resptag = 13'h1ABC;
      if (push) begin
        for (int i = 0; i < 2; i++) begin
          if (a + 64'(4 * i) >= model_pc)
            exp_q.push_back('{pc: a + 64'(4 * i), data: mem_instr(a + 64'(4 * i))});
        end
      end
      @(negedge clk);
      check("respack", 64'(sysbus.bus_respack), 64'd1);
      if (!push) check("drain_no_valid", 64'(instr_valid), 64'd0);
      tick();
    end
    sysbus.bus_respcyc = 1'b0;
    if (push && last == 7) model_pc = cur_line + 64'd64;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: every accepted instruction must match the queue head.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !redirect_valid) begin
      pop_count++;
      check("instr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("instr_pc", instr_pc, mon_e.pc);
        check("instr_data", 64'(instr), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{entry: 64'h1000, ack_delay: 1, exp_req: 64'h1000, exp_cnt: 16, exp_next: 64'h1040};
    vecs[1] = '{entry: 64'h1008, ack_delay: 1, exp_req: 64'h1000, exp_cnt: 14, exp_next: 64'h1040};
    vecs[2] = '{entry: 64'h103C, ack_delay: 3, exp_req: 64'h1000, exp_cnt: 1,  exp_next: 64'h1040};
    vecs[3] = '{entry: 64'h2044, ack_delay: 0, exp_req: 64'h2040, exp_cnt: 15, exp_next: 64'h2080};

    reset = 1'b0;
    entry = 64'h1000;
    enable = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    sysbus.bus_reqack = 1'b0;
    sysbus.bus_respcyc = 1'b1;
    sysbus.bus_resp = '0;
    sysbus.bus_resptag = '0;
    model_pc = '0;
    cur_line = '0;

    // Reset state, with a stray response beat present.
    repeat (3) tick();
    check("rst_reqcyc", 64'(sysbus.bus_reqcyc), 64'd0);
    check("rst_respack", 64'(sysbus.bus_respack), 64'd0);
    check("rst_req", sysbus.bus_req, 64'd0);
    check("rst_reqtag", 64'(sysbus.bus_reqtag), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Out of reset with enable low: stays idle and ignores response beats.
    reset = 1'b1;
    repeat (4) tick();
    check("disabled_busy", 64'(busy), 64'd0);
    check("disabled_reqcyc", 64'(sysbus.bus_reqcyc), 64'd0);
    check("idle_resp_ignored", 64'(sysbus.bus_respack), 64'd0);
    sysbus.bus_respcyc = 1'b0;

    // Table-driven single line fills.
    for (int v = 0; v < 4; v++) begin
      apply_reset(vecs[v].entry);
      enable = 1'b1;
      instr_ready = 1'b1;
      pop_count = 0;
      do_request(vecs[v].exp_req, vecs[v].ack_delay, 1'b0, 64'd0);
      send_beats(0, 7, 1'b1);
      wait_drain();
      check("vec_pop_count", 64'(pop_count), 64'(vecs[v].exp_cnt));
      wait_req(seen);
      check("vec_next_req", sysbus.bus_req, vecs[v].exp_next);
    end

    // Backpressure: a full FIFO blocks the next request until fully drained.
    apply_reset(64'h3000);
    enable = 1'b1;
    instr_ready = 1'b0;
    pop_count = 0;
    do_request(64'h3000, 5, 1'b0, 64'd0);
    send_beats(0, 7, 1'b1);
    saw_req = 1'b0;
    repeat (10) begin
      tick();
      saw_req |= sysbus.bus_reqcyc;
    end
    check("full_no_req", 64'(saw_req), 64'd0);
    check("full_valid", 64'(instr_valid), 64'd1);
    check("full_idle", 64'(busy), 64'd0);
    instr_ready = 1'b1;
    repeat (15) tick();
    instr_ready = 1'b0;
    saw_req = 1'b0;
    repeat (10) begin
      tick();
      saw_req |= sysbus.bus_reqcyc;
    end
    check("partial_no_req", 64'(saw_req), 64'd0);
    check("pop15", 64'(pop_count), 64'd15);
    instr_ready = 1'b1;
    wait_req(seen);
    check("pop16", 64'(pop_count), 64'd16);
    check("bp_next_req", sysbus.bus_req, 64'h3040);

    // Redirect while the request is waiting for its ack.
    apply_reset(64'h1000);
    enable = 1'b1;
    pop_count = 0;
    do_request(64'h1000, 2, 1'b1, 64'h4010);
    send_beats(0, 7, 1'b0);
    do_request(64'h4000, 1, 1'b0, 64'd0);
    send_beats(0, 7, 1'b1);
    wait_drain();
    check("redir_req_pops", 64'(pop_count), 64'd12);

    // Redirect after beat 3 of a fill: flush, drain beats 4..7, refetch.
    apply_reset(64'h1000);
    enable = 1'b1;
    do_request(64'h1000, 1, 1'b0, 64'd0);
    send_beats(0, 3, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    model_pc = 64'h2000;
    exp_q.delete();
    tick();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 64'(instr_valid), 64'd0);
    check("redir_busy", 64'(busy), 64'd1);
    send_beats(4, 7, 1'b0);
    do_request(64'h2000, 1, 1'b0, 64'd0);
    send_beats(0, 7, 1'b1);
    wait_drain();

    // Asynchronous reset during beat 5 abandons the burst.
    apply_reset(64'h5000);
    enable = 1'b1;
    do_request(64'h5000, 1, 1'b0, 64'd0);
    send_beats(0, 4, 1'b1);
    sysbus.bus_respcyc = 1'b1;
    sysbus.bus_resp = {mem_instr(64'h502C), mem_instr(64'h5028)};
    #2;
    reset = 1'b0;
    entry = 64'h6020;
    #1;
    check("async_reqcyc", 64'(sysbus.bus_reqcyc), 64'd0);
    check("async_valid", 64'(instr_valid), 64'd0);
    check("async_respack", 64'(sysbus.bus_respack), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    exp_q.delete();
    sysbus.bus_respcyc = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_pc = 64'h6020;
    pop_count = 0;
    do_request(64'h6000, 1, 1'b0, 64'd0);
    send_beats(0, 7, 1'b1);
    wait_drain();
    check("post_reset_pops", 64'(pop_count), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
